// File: rtl/prbs_gen_multi_if.sv
// Handshake/control bundle for prbs_gen_multi.
//  master : generator side (prbs_gen_multi) - receives control, drives the word stream
//  slave  : sink/controller side - drives control and i_ready, observes the stream
// Signals:
//  i_enable, i_load, i_mode[1:0], i_inject, i_inject_ch[2:0], i_ready  (towards generator)
//  o_valid, o_data[NCH*NB-1:0], o_mode[1:0], o_word_cnt[31:0]            (from generator)
interface prbs_gen_multi_if #(
    parameter int unsigned NCH = 2,
    parameter int unsigned NB  = 4
) ();
    logic                  i_enable;
    logic                  i_load;
    logic [1:0]            i_mode;
    logic                  i_inject;
    logic [2:0]            i_inject_ch;
    logic                  i_ready;
    logic                  o_valid;
    logic [NCH*NB-1:0]     o_data;
    logic [1:0]            o_mode;
    logic [31:0]           o_word_cnt;

    modport master (
        input  i_enable, i_load, i_mode, i_inject, i_inject_ch, i_ready,
        output o_valid, o_data, o_mode, o_word_cnt
    );

    modport slave (
        output i_enable, i_load, i_mode, i_inject, i_inject_ch, i_ready,
        input  o_valid, o_data, o_mode, o_word_cnt
    );
endinterface

// File: rtl/prbs_gen_multi.sv
// Multi-channel PRBS generator: NCH independent LFSRs, NB bits per channel per
// word, run-time polynomial (PRBS7/9/15/31), valid/ready flow control, seed
// reload, single-bit error injection and an accepted-word counter.
// Ports:
//  clock    - system clock
//  i_reset  - asynchronous active-low reset
//  bus      - prbs_gen_multi_if.master (control inputs, i_ready, o_valid,
//             o_data, o_mode, o_word_cnt)
module prbs_gen_multi #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned NB       = 4,
    parameter logic [30:0] SEED     = 31'h000001FF,
    parameter logic [1:0]  MODE_RST = 2'd1
) (
    input  logic              clock,
    input  logic              i_reset,
    prbs_gen_multi_if.master  bus
);

    localparam int unsigned SW = 31;
    localparam int unsigned DW = NCH * NB;
    localparam int unsigned CW = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Active register length for a mode
    function automatic int unsigned len_of(input logic [1:0] m);
        int unsigned l;
        case (m)
            2'd0:    l = 7;
            2'd1:    l = 9;
            2'd2:    l = 15;
            default: l = 31;
        endcase
        return l;
    endfunction

    // Second feedback tap for a mode
    function automatic int unsigned tap_of(input logic [1:0] m);
        int unsigned t;
        case (m)
            2'd0:    t = 6;
            2'd1:    t = 5;
            2'd2:    t = 14;
            default: t = 28;
        endcase
        return t;
    endfunction

    // Channel seed: low L bits of SEED xor channel index; all-zero lock-up state replaced by all ones
    function automatic logic [SW-1:0] seed_of(input logic [1:0] m, input int unsigned k);
        logic [SW-1:0] mask;
        logic [SW-1:0] s;
        mask = SW'((32'd1 << len_of(m)) - 32'd1);
        s    = (SEED & mask) ^ SW'(k);
        if (s == '0) begin
            s = mask;
        end
        return s;
    endfunction

    // One LFSR step; bits above L collect shifted-out history and are never read
    function automatic logic [SW-1:0] step(input logic [SW-1:0] s, input logic [1:0] m);
        logic fb;
        fb = s[5'(len_of(m) - 1)] ^ s[5'(tap_of(m) - 1)];
        return {s[SW-2:0], fb};
    endfunction

    // Next NB output bits, first-in-time at the MSB
    function automatic logic [NB-1:0] top_bits(input logic [SW-1:0] s, input logic [1:0] m);
        logic [NB-1:0] w;
        w = '0;
        for (int b = 0; b < NB; b++) begin
            w[b] = s[5'(len_of(m) - NB + 32'(b))];
        end
        return w;
    endfunction

    state_e                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [NCH-1:0][SW-1:0] lfsr_q, lfsr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NCH-1:0]         pend_q, pend_d;
    logic                   xfer_c;
    logic [DW-1:0]          data_c;

    assign xfer_c = (state_q == ST_RUN) & bus.i_ready;

    // State registers
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RST;
            cnt_q   <= '0;
            pend_q  <= '0;
            for (int k = 0; k < NCH; k++) begin
                lfsr_q[k] <= seed_of(MODE_RST, 32'(k));
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state: load overrides everything, otherwise FSM + advance on transfer
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;

        if (bus.i_load) begin
            state_d = ST_IDLE;
            mode_d  = bus.i_mode;
            cnt_d   = '0;
            pend_d  = '0;
            for (int k = 0; k < NCH; k++) begin
                lfsr_d[k] = seed_of(bus.i_mode, 32'(k));
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_enable) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // An offered word is held until taken even if enable drops
                    if (xfer_c && !bus.i_enable) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (xfer_c) begin
                cnt_d  = cnt_q + 32'd1;
                pend_d = '0;
                for (int k = 0; k < NCH; k++) begin
                    for (int i = 0; i < NB; i++) begin
                        lfsr_d[k] = step(lfsr_d[k], mode_q);
                    end
                end
            end

            // Applied after the transfer clear so a same-cycle inject hits the next word
            if (bus.i_inject) begin
                for (int k = 0; k < NCH; k++) begin
                    if (bus.i_inject_ch == 3'(k)) begin
                        pend_d[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Output word: top NB state bits per channel, MSB flipped when an error is pending
    always_comb begin
        data_c = '0;
        for (int k = 0; k < NCH; k++) begin
            data_c[k*NB +: NB] = top_bits(lfsr_q[k], mode_q) ^ (NB'(pend_q[k]) << (NB - 1));
        end
    end

    assign bus.o_valid    = (state_q == ST_RUN);
    assign bus.o_data     = data_c;
    assign bus.o_mode     = mode_q;
    assign bus.o_word_cnt = cnt_q;

endmodule

// File: tb/tb_prbs_gen_multi.sv
// Self-checking bench for prbs_gen_multi (NCH=2, NB=4).
module tb_prbs_gen_multi;

    localparam int unsigned NCH      = 2;
    localparam int unsigned NB       = 4;
    localparam logic [30:0] SEED     = 31'h000001FF;
    localparam logic [1:0]  MODE_RST = 2'd1;
    localparam int          MAXB     = 20480;
    localparam int          LENS [4] = '{7, 9, 15, 31};
    localparam int          TAPS [4] = '{6, 5, 14, 28};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prbs_gen_multi_if #(.NCH(NCH), .NB(NB)) bus ();

    prbs_gen_multi #(
        .NCH(NCH), .NB(NB), .SEED(SEED), .MODE_RST(MODE_RST)
    ) dut (
        .clock   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: each channel's full output bit stream, produced from the
    // recurrence a[n] = a[n-L] ^ a[n-T] seeded with the seed bits MSB-first.
    bit          seq [NCH][MAXB];
    logic [1:0]  m_mode;
    bit          m_run;
    int          m_pos;
    logic [31:0] m_cnt;
    bit [NCH-1:0] m_pend;
    logic [7:0]  first_w [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic gen_seq(input logic [1:0] m);
        int L;
        int T;
        logic [31:0] sv;
        L = LENS[m];
        T = TAPS[m];
        for (int k = 0; k < NCH; k++) begin
            sv = (32'(SEED) & ((32'd1 << L) - 32'd1)) ^ 32'(k);
            if (sv == 32'd0) sv = (32'd1 << L) - 32'd1;
            for (int i = 0; i < MAXB; i++) begin
                if (i < L) seq[k][i] = sv[L-1-i];
                else       seq[k][i] = seq[k][i-L] ^ seq[k][i-T];
            end
        end
    endtask

    function automatic logic [NCH*NB-1:0] exp_word(input bit with_pend);
        logic [NCH*NB-1:0] w;
        w = '0;
        for (int k = 0; k < NCH; k++) begin
            for (int b = 0; b < NB; b++) w[k*NB + NB-1-b] = seq[k][m_pos+b];
            if (with_pend && m_pend[k]) w[k*NB + NB-1] = ~w[k*NB + NB-1];
        end
        return w;
    endfunction

    task automatic m_reset();
        m_mode = MODE_RST;
        gen_seq(m_mode);
        m_pos  = 0;
        m_cnt  = 32'd0;
        m_pend = '0;
        m_run  = 1'b0;
    endtask

    task automatic m_step();
        bit xfer;
        if (bus.i_load) begin
            m_mode = bus.i_mode;
            gen_seq(m_mode);
            m_pos  = 0;
            m_cnt  = 32'd0;
            m_pend = '0;
            m_run  = 1'b0;
        end else begin
            xfer = m_run && bus.i_ready;
            if (xfer) begin
                m_pos  = m_pos + NB;
                m_cnt  = m_cnt + 32'd1;
                m_pend = '0;
            end
            m_run = bus.i_enable || (m_run && !xfer);
            if (bus.i_inject) begin
                for (int k = 0; k < NCH; k++)
                    if (int'(bus.i_inject_ch) == k) m_pend[k] = 1'b1;
            end
        end
    endtask

    // Model update on the same edges as the design
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("valid", 64'(bus.o_valid), 64'(m_run));
            chk("mode", 64'(bus.o_mode), 64'(m_mode));
            chk("cnt", 64'(bus.o_word_cnt), 64'(m_cnt));
            if (m_run) chk("data", 64'(bus.o_data), 64'(exp_word(1'b1)));
        end
    end

    // Load a mode and start streaming; returns with the first word on the bus
    task automatic start(input logic [1:0] m);
        @(posedge clk); #1;
        bus.i_load = 1'b1;
        bus.i_mode = m;
        @(posedge clk); #1;
        bus.i_load   = 1'b0;
        bus.i_mode   = ~m;
        bus.i_enable = 1'b1;
        @(negedge clk);
        chk("load_valid", 64'(bus.o_valid), 64'd0);
        chk("load_cnt", 64'(bus.o_word_cnt), 64'd0);
        chk("load_mode", 64'(bus.o_mode), 64'(m));
        @(negedge clk);
    endtask

    // Free-running stream of n words: count ones per channel, expect wrap to w0
    task automatic stream_check(input string tag, input int n, input int ones, input logic [7:0] w0);
        int c0;
        int c1;
        c0 = 0;
        c1 = 0;
        chk({tag, "_w0"}, 64'(bus.o_data), 64'(w0));
        for (int i = 0; i < n; i++) begin
            if (i < 4) first_w[i] = bus.o_data;
            c0 += $countones(bus.o_data[3:0]);
            c1 += $countones(bus.o_data[7:4]);
            @(negedge clk);
        end
        chk({tag, "_wrap"}, 64'(bus.o_data), 64'(w0));
        chk({tag, "_cnt"}, 64'(bus.o_word_cnt), 64'(n));
        chk({tag, "_ones0"}, 64'(c0), 64'(ones));
        chk({tag, "_ones1"}, 64'(c1), 64'(ones));
    endtask

    initial begin
        logic [31:0] c_before;
        logic [7:0]  clean;

        rst_n           = 1'b0;
        bus.i_enable    = 1'b0;
        bus.i_load      = 1'b0;
        bus.i_mode      = 2'd0;
        bus.i_inject    = 1'b0;
        bus.i_inject_ch = 3'd0;
        bus.i_ready     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_mode", 64'(bus.o_mode), 64'd1);
        chk("rst_cnt", 64'(bus.o_word_cnt), 64'd0);
        chk("rst_data", 64'(bus.o_data), 64'h0FF);

        // PRBS9 from reset: bits 1x9,0x5,1,1 on ch0; ch1 seed 1FE
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 bus.i_enable = 1'b1;
        @(negedge clk);
        chk("idle_before_run", 64'(bus.o_valid), 64'd0);
        @(negedge clk);
        stream_check("p9", 511, 1024, 8'hFF);
        chk("p9_w1", 64'(first_w[1]), 64'h0FF);
        chk("p9_w2", 64'(first_w[2]), 64'h008);
        chk("p9_w3", 64'(first_w[3]), 64'h073);

        // PRBS7: 127 words = 4 full periods per channel
        start(2'd0);
        stream_check("p7", 127, 256, 8'hFF);

        // PRBS31 long run, checked word by word against the model
        start(2'd3);
        chk("p31_w0", 64'(bus.o_data), 64'h000);
        repeat (4096) @(negedge clk);
        chk("p31_cnt", 64'(bus.o_word_cnt), 64'd4096);

        // Random backpressure with sporadic injection (incl. out-of-range channels)
        start(2'd1);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            bus.i_ready     = 1'($urandom_range(0, 1));
            bus.i_inject    = ($urandom_range(0, 15) == 0);
            bus.i_inject_ch = 3'($urandom_range(0, 7));
        end
        @(posedge clk); #1;
        bus.i_inject = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_stall", 64'(bus.o_valid), 64'd1);
        end
        c_before = m_cnt;
        @(posedge clk); #1 bus.i_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_idle", 64'(bus.o_valid), 64'd0);
        chk("drop_cnt", 64'(bus.o_word_cnt), 64'(c_before + 32'd1));
        @(negedge clk);
        chk("drop_stay_idle", 64'(bus.o_valid), 64'd0);

        // Injection on ch1 while stalled
        @(posedge clk); #1;
        bus.i_ready  = 1'b0;
        bus.i_enable = 1'b1;
        @(posedge clk); #1;
        clean           = exp_word(1'b0);
        bus.i_inject    = 1'b1;
        bus.i_inject_ch = 3'd1;
        @(posedge clk); #1 bus.i_inject = 1'b0;
        @(negedge clk);
        chk("inj_ch1", 64'(bus.o_data), 64'(clean ^ 8'h80));
        @(posedge clk); #1 bus.i_ready = 1'b1;
        @(posedge clk); #1 bus.i_ready = 1'b0;
        @(negedge clk);
        chk("inj_cleared", 64'(bus.o_data), 64'(exp_word(1'b0)));
        // Injection coincident with a transfer lands on the following word
        @(posedge clk); #1;
        bus.i_ready     = 1'b1;
        bus.i_inject    = 1'b1;
        bus.i_inject_ch = 3'd0;
        @(posedge clk); #1;
        bus.i_ready  = 1'b0;
        bus.i_inject = 1'b0;
        @(negedge clk);
        chk("inj_xfer", 64'(bus.o_data), 64'(exp_word(1'b0) ^ 8'h08));

        // Load mid-run (inject in the same cycle is discarded)
        @(posedge clk); #1 bus.i_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus.i_load      = 1'b1;
        bus.i_mode      = 2'd2;
        bus.i_inject    = 1'b1;
        bus.i_inject_ch = 3'd0;
        @(posedge clk); #1;
        bus.i_load   = 1'b0;
        bus.i_inject = 1'b0;
        bus.i_mode   = 2'd3;
        @(negedge clk);
        chk("abort_valid", 64'(bus.o_valid), 64'd0);
        chk("abort_cnt", 64'(bus.o_word_cnt), 64'd0);
        chk("abort_mode", 64'(bus.o_mode), 64'd2);
        @(negedge clk);
        chk("p15_w0", 64'(bus.o_data), 64'h000);
        repeat (30) @(negedge clk);

        // Asynchronous reset mid-run
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.o_valid), 64'd0);
        chk("arst_cnt", 64'(bus.o_word_cnt), 64'd0);
        chk("arst_mode", 64'(bus.o_mode), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle", 64'(bus.o_valid), 64'd0);
        @(negedge clk);
        chk("arst_w0", 64'(bus.o_data), 64'h0FF);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
